evo_servo_ctrl: RTL
===================

Name: evo_servo_ctrl

Overview:
- Servo control block that consumes the EVO_SERVO_ADDR CSR address space defined in the OpenEvo XB address package.
- Decodes CSR reads and writes at that base address and holds per-channel control, period and pulse-width registers.
- Generates NUM_CH hobby-servo PWM outputs from a microsecond timebase.
- Pulse and period updates are double-buffered so they take effect only at a frame boundary, which prevents glitched pulses.

Parameters:
- BASE_ADDR, 12'h8AA (EVO_SERVO_ADDR): first CSR address of the block.
- NUM_CH, 4: number of servo channels, range 1..8.
- CLKS_PER_US, 16: clock cycles per microsecond tick, must be ≥2.
- PERIOD_RST, 20000: reset frame period in µs.
- PULSE_RST, 1500: reset pulse width in µs for every channel.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- csr_addr  in  12  CSR word address
- csr_wr  in  1  write strobe, single cycle
- csr_wrdata  in  32  write data
- csr_rd  in  1  read strobe, single cycle
- csr_rddata  out  32  read data
- csr_rdvalid  out  1  read data valid, single-cycle pulse
- servo_out  out  NUM_CH  PWM outputs
- frame_start  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Register map, full 32-bit access, unused bits read 0 and are ignored on write:
  - BASE+0 CTRL: [NUM_CH-1:0] channel enable.
  - BASE+1 PERIOD: [15:0] frame period in µs.
  - BASE+2+ch PULSE[ch]: [15:0] pulse width in µs.
- Addresses outside BASE..BASE+1+NUM_CH: no register change, no csr_rdvalid, csr_rddata held at 0.
- Reads:
  - csr_rddata and csr_rdvalid are registered and valid exactly 1 cycle after csr_rd.
  - csr_rddata returns 0 when csr_rdvalid is low.
- Simultaneous csr_rd and csr_wr to the same address: both are accepted; the read returns the pre-write value.
- A write of 0 to PERIOD is ignored and the previous value is retained.
- Shadow/active split: CTRL, PERIOD and PULSE are shadow registers; pulse_act, period_act and en_act are the active copies.
- Timebase:
  - presc counts 0..CLKS_PER_US-1; tick asserts when presc==CLKS_PER_US-1.
  - us_cnt increments on tick and wraps from period_act-1 to 0.
- Frame boundary is defined as either:
  - a tick with us_cnt==period_act-1, or
  - the cycle after CTRL is written nonzero while en_act==0 (restart).
- At a frame boundary:
  - active copies load from the shadows;
  - us_cnt and presc are set to 0;
  - frame_start pulses on the following cycle.
- Idle: when the shadow CTRL enables are all 0, presc, us_cnt and en_act are cleared immediately (next edge) and frame_start stays low.
- Disable of any channel (CTRL bit cleared) clears the matching en_act bit on the next edge, without waiting for the boundary. Enables and all PULSE/PERIOD changes wait for the boundary.
- Output:
  - servo_out[ch] is registered: en_act[ch] && (us_cnt < pulse_act[ch]).
  - High time is exactly pulse*CLKS_PER_US clocks.
  - pulse=0 gives a constant low output.
  - pulse ≥ period_act gives a constant high output for the whole frame.
- Latency: servo_out rises 2 cycles after the boundary-load edge, i.e. 3 cycles after the enabling CTRL write from idle.
- Reset values:
  - csr_rddata=0, csr_rdvalid=0, servo_out=0, frame_start=0.
  - CTRL=0, PERIOD=PERIOD_RST, PULSE[*]=PULSE_RST.
  - Active registers, presc and us_cnt all 0.
- Reset mid-frame: all outputs drop low asynchronously and the block returns to idle.

Test Plan:
- Reset, then read BASE+0, BASE+1, BASE+2 → rdvalid 1 cycle after each rd; data 0, 20000, 1500; servo_out stays 0.
- CLKS_PER_US=4: write PERIOD=20, PULSE[0]=5, CTRL=1 → servo_out[0] high 20 clocks, low 60 clocks, repeating; frame_start every 80 clocks.
- Mid-frame write PULSE[0]=10 → current frame keeps the 20-clock pulse; next frame gives a 40-clock pulse.
- PULSE[1]=0 and PULSE[2]=25 with CTRL=7 → servo_out[1] constant 0, servo_out[2] constant 1, servo_out[0] unchanged.
- Write CTRL=0 mid-pulse → servo_out low next cycle; frame_start stops. Write PERIOD=0 → read returns 20.
- Read BASE+6 (out of range for NUM_CH=4) → no rdvalid. Assert reset_n low mid-pulse → servo_out 0 immediately; registers at reset values.

Source files
------------

// File: rtl/evo_servo_ctrl.sv
// evo_servo_ctrl: CSR-mapped hobby-servo PWM generator, NUM_CH channels on a microsecond timebase.
// Latency: CSR read data 1 cycle after csr_rd; servo_out rises 3 cycles after an enabling CTRL write from idle.
// Backpressure: none; CSR strobes are always accepted, and out-of-range accesses are dropped silently.
// Ports: clk/reset_n; csr_addr/csr_wr/csr_wrdata/csr_rd in; csr_rddata/csr_rdvalid out;
//        servo_out[NUM_CH-1:0] PWM outputs; frame_start one-cycle pulse per frame.
module evo_servo_ctrl #(
  parameter logic [11:0] BASE_ADDR   = 12'h8AA,
  parameter int          NUM_CH      = 4,
  parameter int          CLKS_PER_US = 16,
  parameter logic [15:0] PERIOD_RST  = 16'd20000,
  parameter logic [15:0] PULSE_RST   = 16'd1500
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [11:0]       csr_addr,
  input  logic              csr_wr,
  input  logic [31:0]       csr_wrdata,
  input  logic              csr_rd,
  output logic [31:0]       csr_rddata,
  output logic              csr_rdvalid,
  output logic [NUM_CH-1:0] servo_out,
  output logic              frame_start
);

  localparam int          PW        = $clog2(CLKS_PER_US);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_US - 1);

  // Shadow (CSR-visible) registers
  logic [NUM_CH-1:0]       ctrl_q, ctrl_d;
  logic [15:0]             period_q, period_d;
  logic [NUM_CH-1:0][15:0] pulse_q, pulse_d;

  // Active copies used by the PWM engine
  logic [NUM_CH-1:0]       en_act_q, en_act_d;
  logic [15:0]             period_act_q, period_act_d;
  logic [NUM_CH-1:0][15:0] pulse_act_q, pulse_act_d;

  // Timebase and output pipeline
  logic [PW-1:0]     presc_q, presc_d;
  logic [15:0]       us_cnt_q, us_cnt_d;
  logic              restart_q, restart_d;
  logic              frame_start_q, frame_start_d;
  logic [NUM_CH-1:0] lt_q, lt_d;
  logic [NUM_CH-1:0] servo_q, servo_d;
  logic [31:0]       rddata_q, rddata_d;
  logic              rdvalid_q, rdvalid_d;

  logic [11:0] off;
  logic        hit;
  logic        tick;
  logic        boundary;
  logic [31:0] rd_mux;

  // Subtraction wraps addresses below BASE to large offsets, so one compare covers both ends.
  assign off  = csr_addr - BASE_ADDR;
  assign hit  = off < 12'(NUM_CH + 2);
  assign tick = (presc_q == PRESC_MAX);
  // restart_q is set by a nonzero CTRL write while nothing was active: start a fresh frame now.
  assign boundary = restart_q || (tick && (us_cnt_q == period_act_q - 16'd1));

  // CSR decode; reads always see the pre-write (registered) value.
  always_comb begin
    ctrl_d    = ctrl_q;
    period_d  = period_q;
    pulse_d   = pulse_q;
    rd_mux    = '0;
    restart_d = 1'b0;
    if (csr_wr && off == 12'd0) begin
      ctrl_d    = csr_wrdata[NUM_CH-1:0];
      restart_d = (csr_wrdata[NUM_CH-1:0] != '0) && (en_act_q == '0);
    end
    if (csr_wr && off == 12'd1 && csr_wrdata[15:0] != 16'd0) period_d = csr_wrdata[15:0];
    for (int c = 0; c < NUM_CH; c++) begin
      if (csr_wr && off == 12'(c + 2)) pulse_d[c] = csr_wrdata[15:0];
    end
    if (off == 12'd0) rd_mux = 32'(ctrl_q);
    if (off == 12'd1) rd_mux = {16'd0, period_q};
    for (int c = 0; c < NUM_CH; c++) begin
      if (off == 12'(c + 2)) rd_mux = {16'd0, pulse_q[c]};
    end
    rdvalid_d = csr_rd && hit;
    rddata_d  = rdvalid_d ? rd_mux : 32'd0;
  end

  // Timebase, frame-boundary loading and PWM compare.
  always_comb begin
    presc_d       = tick ? '0 : presc_q + PW'(1);
    us_cnt_d      = tick ? us_cnt_q + 16'd1 : us_cnt_q;
    en_act_d      = en_act_q;
    period_act_d  = period_act_q;
    pulse_act_d   = pulse_act_q;
    frame_start_d = 1'b0;
    if (boundary) begin
      en_act_d      = ctrl_q;
      period_act_d  = period_q;
      pulse_act_d   = pulse_q;
      presc_d       = '0;
      us_cnt_d      = 16'd0;
      frame_start_d = 1'b1;
    end
    if (ctrl_q == '0) begin
      presc_d       = '0;
      us_cnt_d      = 16'd0;
      en_act_d      = '0;
      frame_start_d = 1'b0;
    end
    // Disables bypass the boundary; enables can only arrive via the load above.
    en_act_d = en_act_d & ctrl_d;
    // Two-stage output: enable is applied in both stages so a disable drops the pin one cycle later.
    for (int c = 0; c < NUM_CH; c++) begin
      lt_d[c] = en_act_q[c] && (us_cnt_q < pulse_act_q[c]);
    end
    servo_d = lt_q & en_act_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q        <= '0;
      period_q      <= PERIOD_RST;
      pulse_q       <= {NUM_CH{PULSE_RST}};
      en_act_q      <= '0;
      period_act_q  <= 16'd0;
      pulse_act_q   <= '0;
      presc_q       <= '0;
      us_cnt_q      <= 16'd0;
      restart_q     <= 1'b0;
      frame_start_q <= 1'b0;
      lt_q          <= '0;
      servo_q       <= '0;
      rddata_q      <= 32'd0;
      rdvalid_q     <= 1'b0;
    end else begin
      ctrl_q        <= ctrl_d;
      period_q      <= period_d;
      pulse_q       <= pulse_d;
      en_act_q      <= en_act_d;
      period_act_q  <= period_act_d;
      pulse_act_q   <= pulse_act_d;
      presc_q       <= presc_d;
      us_cnt_q      <= us_cnt_d;
      restart_q     <= restart_d;
      frame_start_q <= frame_start_d;
      lt_q          <= lt_d;
      servo_q       <= servo_d;
      rddata_q      <= rddata_d;
      rdvalid_q     <= rdvalid_d;
    end
  end

  assign csr_rddata  = rddata_q;
  assign csr_rdvalid = rdvalid_q;
  assign servo_out   = servo_q;
  assign frame_start = frame_start_q;

endmodule
